param_ram_arbiter: RTL and testbench
====================================

// Module: param_ram_arbiter
// PURPOSE
//  Shares one parameter-RAM s2 port (rx or tx bank, 11-bit word addr, 32-bit data) between NUM_REQ
//  fabric requesters (observer loop, parameter loader, debug readback). Round-robin, one access/cycle.
//  Sits between fabric logic and parameter_sys_parameter_*_ram_s2_*; returns read data tagged per requester.
// PARAMETERS
//  NUM_REQ   4   requester count (2..8)
//  ADDR_W    11  RAM word address width
//  DATA_W    32  RAM data width
//  READ_LAT  1   RAM readdata latency, cycles after registered command (1..3)
// PORTS
//  clk_clk        in   1                 sole clock
//  reset_reset_n  in   1                 synchronous active-low reset
//  req            in   NUM_REQ           per-requester access request, held until gnt
//  req_we         in   NUM_REQ           1=write, 0=read
//  req_addr       in   NUM_REQ*ADDR_W    packed word addresses
//  req_wdata      in   NUM_REQ*DATA_W    packed write data
//  req_be         in   NUM_REQ*DATA_W/8  packed byte enables
//  gnt            out  NUM_REQ           one-hot, combinational; command accepted this cycle
//  rvalid         out  NUM_REQ           one-hot, one-cycle pulse, read data for that requester
//  rdata          out  DATA_W            read data, valid only with rvalid
//  ram_address    out  ADDR_W            -> s2_address
//  ram_chipselect out  1                 -> s2_chipselect
//  ram_clken      out  1                 -> s2_clken
//  ram_write      out  1                 -> s2_write
//  ram_writedata  out  DATA_W            -> s2_writedata
//  ram_byteenable out  DATA_W/8          -> s2_byteenable
//  ram_readdata   in   DATA_W            <- s2_readdata
// BEHAVIOUR
//  - Reset: gnt=0, rvalid=0, rdata=0, ram_chipselect=0, ram_write=0, ram_address=0, ram_writedata=0,
//    ram_byteenable=0, ram_clken=0; rr pointer = NUM_REQ-1 (requester 0 wins first); read pipe flushed.
//  - ram_clken=1 every cycle after reset release.
//  - Cycle N: gnt[i]=1 for winner among req; requester must keep cmd stable until gnt, may change it at N+1.
//  - Winner: first set req bit searching from (ptr+1) mod NUM_REQ upward; ptr <= i on grant. No req -> no gnt, ptr held.
//  - Cycle N+1: ram_* carries registered winner cmd, chipselect=1 for exactly one cycle; idle cycles chipselect=0,
//    write=0, other ram_* hold last values.
//  - Reads: requester id enters READ_LAT-deep tag pipe; rvalid[id] and rdata (registered ram_readdata) at
//    N+1+READ_LAT+1, i.e. N+2+READ_LAT. Writes produce no rvalid.
//  - Throughput 1 cmd/cycle; back-to-back reads from different requesters return in grant order, no gaps.
//  - Same requester held req continuously: granted again only after other pending requesters each got one grant.
//  - be=0 write: issued to RAM unchanged (no-op in RAM), consumes a slot.
//  - req_we, req_addr, req_wdata, req_be of non-winners ignored.
//  - Reset mid-operation: tag pipe cleared, in-flight reads never return rvalid; any registered cmd dropped
//    (chipselect=0 next cycle).
// CONFIGURATION
//  PARAM_ARB_PRIO0_EN defined: requester 0 absolute priority; rr applies among 1..NUM_REQ-1 only when req[0]=0;
//   grant to 0 does not move ptr.
//  Undefined: pure round-robin over all NUM_REQ as above.
// STRUCTURE
//  Package param_arb_pkg: ADDR_W/DATA_W/BE_W localparams, req_id_t (clog2(NUM_REQ)), ram_cmd_t struct
//  {we, addr, wdata, be}.
//  Sub-module rr_arbiter (req vector + ptr -> one-hot gnt + id, ptr update); top holds cmd mux, cmd register,
//  tag pipe.
// TESTING
//  1 Reset: reset_reset_n=0 with req=4'hF -> gnt=0, chipselect=0, clken=0; release -> first gnt=4'b0001.
//  2 Single read: req[2], addr=0x155, RAM word=0xDEADBEEF, READ_LAT=1 -> gnt[2] at N, chipselect+addr 0x155
//    at N+1, rvalid=4'b0100, rdata=0xDEADBEEF at N+3.
//  3 Contention: req=4'hF held, each released after gnt -> grants 0,1,2,3 in consecutive cycles,
//    4 chipselect cycles.
//  4 Write then read: req[1] write 0x7FF data 0x12345678 be=4'b0011, then read 0x7FF -> rdata=0x00005678
//    over prior 0.
//  5 Reset mid-read: reset asserted cycle after read cmd issued -> no rvalid ever for it; post-reset
//    read correct.
//  6 PRIO0_EN: req[0] and req[3] held 3 cycles -> gnt[0] all 3 cycles; undefined -> alternating 0,3,0.

Source files
------------

// File: rtl/param_ram_arbiter_pkg.sv
// param_arb_pkg: shared widths, command and read-tag types for param_ram_arbiter.
package param_arb_pkg;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_REQ = 8;

    // Sized for the largest supported requester count so one type serves every NUM_REQ.
    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } ram_cmd_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/param_ram_arbiter_if.sv
// param_ram_arb_if: fabric requester bus plus parameter-RAM s2 port of param_ram_arbiter.
interface param_ram_arb_if #(parameter int NUM_REQ = 4);
    import param_arb_pkg::*;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         ram_address;
    logic                      ram_chipselect;
    logic                      ram_clken;
    logic                      ram_write;
    logic [DATA_W-1:0]         ram_writedata;
    logic [BE_W-1:0]           ram_byteenable;
    logic [DATA_W-1:0]         ram_readdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_be, ram_readdata,
        output gnt, rvalid, rdata, ram_address, ram_chipselect, ram_clken, ram_write,
               ram_writedata, ram_byteenable
    );
    modport master (
        output req, req_we, req_addr, req_wdata, req_be, ram_readdata,
        input  gnt, rvalid, rdata, ram_address, ram_chipselect, ram_clken, ram_write,
               ram_writedata, ram_byteenable
    );
endinterface

// File: rtl/param_ram_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant from (ptr+1) upward, pointer moves to the winner.
// PARAM_ARB_PRIO0_EN gives requester 0 absolute priority without moving the pointer.
module rr_arbiter
    import param_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output req_id_t      id_o
);
    req_id_t ptr_q;
    int      d;
    int      best_d;
    logic    hold;

    // Smallest circular distance from ptr+1 wins.
    always_comb begin
        gnt_o  = '0;
        id_o   = '0;
        d      = 0;
        best_d = N;
        hold   = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - int'(ptr_q) - 1) % N;
            if (req_i[i] && d < best_d) begin
                best_d = d;
                id_o   = req_id_t'(i);
            end
        end
`ifdef PARAM_ARB_PRIO0_EN
        if (req_i[0]) begin
            id_o = '0;
            hold = 1'b1;
        end
`else
        hold = 1'b0;
`endif
        if (|req_i) gnt_o = N'(1) << id_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= req_id_t'(N - 1);
        else if (|req_i && !hold) ptr_q <= id_o;
    end
endmodule

// File: rtl/param_ram_arbiter.sv
// param_ram_arbiter: round-robin sharing of one parameter-RAM s2 port with tagged read returns.
// PARAM_ARB_PRIO0_EN (in rr_arbiter) selects absolute priority for requester 0.
module param_ram_arbiter
    import param_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int READ_LAT = 1
) (
    input logic             clk_clk,
    input logic             reset_reset_n,
    param_ram_arb_if.slave  bus
);
    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] gnt;
    req_id_t            win_id;
    req_id_t            id_q;
    ram_cmd_t           cmd_d;
    ram_cmd_t           cmd_q;
    logic               cs_q;
    logic               clken_q;
    tag_t               pipe_q [READ_LAT];
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    assign req_v = bus.req & {NUM_REQ{reset_reset_n}};

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .req_i (req_v),
        .gnt_o (gnt),
        .id_o  (win_id)
    );

    always_comb begin
        cmd_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) cmd_d = '{we: bus.req_we[i], addr: bus.req_addr[i*ADDR_W +: ADDR_W],
                                  wdata: bus.req_wdata[i*DATA_W +: DATA_W], be: bus.req_be[i*BE_W +: BE_W]};
    end

    // Tag pipe lines the requester id up with ram_readdata, READ_LAT cycles after the command.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cs_q     <= 1'b0;
            cmd_q    <= '0;
            id_q     <= '0;
            clken_q  <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            for (int k = 0; k < READ_LAT; k++) pipe_q[k] <= '0;
        end else begin
            clken_q <= 1'b1;
            cs_q    <= |gnt;
            if (|gnt) begin
                cmd_q <= cmd_d;
                id_q  <= win_id;
            end else cmd_q.we <= 1'b0;
            pipe_q[0] <= '{v: cs_q & ~cmd_q.we, id: id_q};
            for (int k = 1; k < READ_LAT; k++) pipe_q[k] <= pipe_q[k-1];
            rvalid_q <= pipe_q[READ_LAT-1].v ? NUM_REQ'(1) << pipe_q[READ_LAT-1].id : '0;
            if (pipe_q[READ_LAT-1].v) rdata_q <= bus.ram_readdata;
        end
    end

    assign bus.gnt            = gnt;
    assign bus.rvalid         = rvalid_q;
    assign bus.rdata          = rdata_q;
    assign bus.ram_address    = cmd_q.addr;
    assign bus.ram_chipselect = cs_q;
    assign bus.ram_clken      = clken_q;
    assign bus.ram_write      = cmd_q.we;
    assign bus.ram_writedata  = cmd_q.wdata;
    assign bus.ram_byteenable = cmd_q.be;
endmodule

// File: tb/tb_param_ram_arbiter.sv
// tb_param_ram_arbiter: table vectors, directed corner sequences and random traffic vs a reference model.
module tb_param_ram_arbiter;
    import param_arb_pkg::*;
    localparam int N  = 4;
    localparam int RL = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_ram_arb_if #(.NUM_REQ(N)) bus ();
    param_ram_arbiter #(.NUM_REQ(N), .READ_LAT(RL)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM behind the s2 port
    bit [DATA_W-1:0] mem     [2**ADDR_W];
    bit [DATA_W-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (bus.ram_chipselect && bus.ram_write)
            for (int b = 0; b < BE_W; b++)
                if (bus.ram_byteenable[b]) mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
        rd_pipe[0] <= mem[bus.ram_address];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.ram_readdata = rd_pipe[RL-1];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: arbitration rule, memory image and expected read returns
    typedef struct {int id; logic [DATA_W-1:0] d; int due;} rd_t;
    rd_t             q [$];
    bit [DATA_W-1:0] ref_mem [2**ADDR_W];
    bit              mon_en    = 0;
    int              ptr_m     = N - 1;
    bit              exp_cs    = 0;
    bit              exp_we    = 0;
    bit              exp_clken = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd;
    logic [BE_W-1:0]   exp_be;
    logic [N-1:0]      m_ev;
    logic [DATA_W-1:0] m_ed;
    int                m_w;

    function automatic int winner(logic [N-1:0] r, int p);
`ifdef PARAM_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(negedge clk) if (mon_en) begin
        m_ev = '0;
        m_ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            m_ev = N'(1) << q[0].id;
            m_ed = q[0].d;
            void'(q.pop_front());
        end
        chk("rvalid", bus.rvalid, m_ev);
        if (m_ev != '0) chk("rdata", bus.rdata, m_ed);
        chk("clken", bus.ram_clken, exp_clken);
        chk("chipselect", bus.ram_chipselect, exp_cs);
        chk("write", bus.ram_write, exp_we);
        if (exp_cs) chk("address", bus.ram_address, exp_addr);
        if (exp_cs && exp_we) begin
            chk("writedata", bus.ram_writedata, exp_wd);
            chk("byteenable", bus.ram_byteenable, exp_be);
        end
        m_w = rst_n ? winner(bus.req, ptr_m) : -1;
        chk("gnt", bus.gnt, m_w < 0 ? 64'd0 : 64'd1 << m_w);
        exp_clken = rst_n;
        exp_cs    = (m_w >= 0);
        exp_we    = 1'b0;
        if (!rst_n) begin
            q.delete();
            ptr_m = N - 1;
        end else if (m_w >= 0) begin
`ifdef PARAM_ARB_PRIO0_EN
            if (m_w != 0) ptr_m = m_w;
`else
            ptr_m = m_w;
`endif
            exp_addr = bus.req_addr[m_w*ADDR_W +: ADDR_W];
            exp_we   = bus.req_we[m_w];
            exp_wd   = bus.req_wdata[m_w*DATA_W +: DATA_W];
            exp_be   = bus.req_be[m_w*BE_W +: BE_W];
            if (exp_we) begin
                for (int b = 0; b < BE_W; b++) if (exp_be[b]) ref_mem[exp_addr][8*b +: 8] = exp_wd[8*b +: 8];
            end else q.push_back('{m_w, ref_mem[exp_addr], cyc + 2 + RL});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(int i, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [BE_W-1:0] be);
        bus.req_we[i]                   = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
        bus.req_be[i*BE_W +: BE_W]      = be;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(int i, output int c);
        c = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.gnt[i]) begin
                c = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL gnt_wait%0d: no grant within 20 cycles", i);
    endtask

    typedef struct {logic [N-1:0] req; logic [N-1:0] gnt;} vec_t;
    vec_t tbl [12];

    initial begin
        int c;
        int cnt;
        logic [N-1:0] g;
`ifdef PARAM_ARB_PRIO0_EN
        tbl = '{'{4'b1001, 4'b0001}, '{4'b1001, 4'b0001}, '{4'b1001, 4'b0001}, '{4'b0001, 4'b0001},
                '{4'b0110, 4'b0010}, '{4'b0110, 4'b0100}, '{4'b0000, 4'b0000}, '{4'b1111, 4'b0001},
                '{4'b1111, 4'b0001}, '{4'b0101, 4'b0001}, '{4'b0011, 4'b0001}, '{4'b1010, 4'b1000}};
`else
        tbl = '{'{4'b1001, 4'b0001}, '{4'b1001, 4'b1000}, '{4'b1001, 4'b0001}, '{4'b0001, 4'b0001},
                '{4'b0110, 4'b0010}, '{4'b0110, 4'b0100}, '{4'b0000, 4'b0000}, '{4'b1111, 4'b1000},
                '{4'b1111, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0011, 4'b0001}, '{4'b1010, 4'b0010}};
`endif
        bus.req       = '1;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        // Reset state with all requests asserted, then first grant
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        chk("t1_gnt", bus.gnt, 0);
        chk("t1_cs", bus.ram_chipselect, 0);
        chk("t1_clken", bus.ram_clken, 0);
        chk("t1_rvalid", bus.rvalid, 0);
        chk("t1_rdata", bus.rdata, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_gnt", bus.gnt, 4'b0001);
        step();
        bus.req = '0;
        // Arbitration table from a fresh pointer
        do_reset();
        foreach (tbl[v]) begin
            step();
            bus.req = tbl[v].req;
            for (int i = 0; i < N; i++) set_cmd(i, 1'b0, ADDR_W'(v), '0, '0);
            @(negedge clk);
            chk($sformatf("tbl%0d", v), bus.gnt, tbl[v].gnt);
        end
        step();
        bus.req = '0;
        // Full contention, each requester released after its grant
        do_reset();
        step();
        bus.req = '1;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            g = bus.gnt;
            cnt += int'(bus.ram_chipselect);
            chk($sformatf("t3_order%0d", k), g, N'(1) << k);
            step();
            bus.req = bus.req & ~g;
        end
        repeat (2) begin
            @(negedge clk);
            cnt += int'(bus.ram_chipselect);
        end
        chk("t3_cs_cycles", cnt, 4);
        // Single read with latency check
        step();
        set_cmd(0, 1'b1, 11'h155, 32'hDEADBEEF, 4'hF);
        bus.req[0] = 1'b1;
        wait_gnt(0, c);
        step();
        bus.req[0] = 1'b0;
        set_cmd(2, 1'b0, 11'h155, '0, '0);
        bus.req[2] = 1'b1;
        wait_gnt(2, c);
        step();
        bus.req[2] = 1'b0;
        @(negedge clk);
        chk("t2_cs", bus.ram_chipselect, 1);
        chk("t2_addr", bus.ram_address, 11'h155);
        repeat (2) @(negedge clk);
        chk("t2_rvalid", bus.rvalid, 4'b0100);
        chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
        // Partial-byte write then read back
        step();
        set_cmd(1, 1'b1, 11'h7FF, 32'h12345678, 4'b0011);
        bus.req[1] = 1'b1;
        wait_gnt(1, c);
        step();
        set_cmd(1, 1'b0, 11'h7FF, '0, '0);
        wait_gnt(1, c);
        step();
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_rvalid", bus.rvalid, 4'b0010);
        chk("t4_rdata", bus.rdata, 32'h00005678);
        // Reset while a read is in flight
        step();
        set_cmd(3, 1'b0, 11'h155, '0, '0);
        bus.req[3] = 1'b1;
        wait_gnt(3, c);
        step();
        bus.req[3] = 1'b0;
        step();
        rst_n = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t5_no_rvalid", bus.rvalid, 0);
            step();
            if (t == 1) rst_n = 1'b1;
        end
        bus.req[3] = 1'b1;
        wait_gnt(3, c);
        step();
        bus.req[3] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_post_rvalid", bus.rvalid, 4'b1000);
        chk("t5_post_rdata", bus.rdata, 32'hDEADBEEF);
        // Random traffic with occasional one-cycle resets
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            g = bus.gnt;
            step();
            rst_n = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < N; i++)
                if (g[i] || !bus.req[i]) begin
                    bus.req[i] = ($urandom_range(0, 2) != 0);
                    set_cmd(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom,
                            BE_W'($urandom_range(0, 15)));
                end
        end
        step();
        rst_n   = 1'b1;
        bus.req = '0;
        repeat (RL + 4) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
